// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the EX/MEM pipeline stage.
//   - ALUCtrl encodings driven to the ALU
//   - EX-stage trap FSM state type
//   - EX/MEM payload struct carried through the skid buffer
package cpu_pkg;

  localparam int unsigned CPU_DW = 32;
  localparam int unsigned CPU_RW = 5;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_ADDU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;

  typedef enum logic {
    RUN       = 1'b0,
    TRAP_HOLD = 1'b1
  } exstate_t;

  typedef struct packed {
    logic [CPU_DW-1:0] c;
    logic [CPU_DW-1:0] store_data;
    logic [CPU_DW-1:0] pc;
    logic [CPU_RW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_payload_t;

  // Signed add/sub are the only ops whose overflow is architecturally visible.
  function automatic logic is_signed_arith(input logic [2:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer.
//   i_push/i_push_data : enqueue request (caller guarantees room)
//   i_pop_ready        : consumer accepts head this cycle
//   i_flush            : synchronous kill of both entries, wins over push
//   o_out_valid/o_out_data : head (MAIN) entry
//   o_skid_valid_nxt   : next-state SKID occupancy, lets the caller register ready
module skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  output logic         o_skid_valid_nxt
);

  logic         r_main_v;
  logic         r_skid_v;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;

  logic w_pop;
  logic w_main_v_nxt;
  logic w_skid_v_nxt;
  logic w_main_from_in;
  logic w_main_from_skid;
  logic w_skid_from_in;

  always_comb begin
    w_pop            = r_main_v && i_pop_ready;
    w_main_v_nxt     = r_main_v;
    w_skid_v_nxt     = r_skid_v;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    if (i_flush) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
    end else if (!r_main_v) begin
      w_main_v_nxt   = i_push;
      w_main_from_in = i_push;
    end else if (w_pop) begin
      if (r_skid_v) begin
        // SKID promotes to head; a concurrent push refills SKID.
        w_main_from_skid = 1'b1;
        w_skid_v_nxt     = i_push;
        w_skid_from_in   = i_push;
      end else begin
        w_main_v_nxt   = i_push;
        w_main_from_in = i_push;
      end
    end else if (i_push && !r_skid_v) begin
      w_skid_v_nxt   = 1'b1;
      w_skid_from_in = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else begin
      r_main_v <= w_main_v_nxt;
      r_skid_v <= w_skid_v_nxt;
      if (w_main_from_skid) begin
        r_main <= r_skid;
      end else if (w_main_from_in) begin
        r_main <= i_push_data;
      end
      if (w_skid_from_in) begin
        r_skid <= i_push_data;
      end
    end
  end

  assign o_out_valid      = r_main_v;
  assign o_out_data       = r_main;
  assign o_skid_valid_nxt = w_skid_v_nxt;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage downstream of the 32-bit ALU.
// Captures ALU result and control bits into a 2-entry skid buffer, resolves
// BEQ from the zero flag (one-cycle redirect pulse), and raises a precise
// overflow trap for signed add/sub (exc level held until exc_ack).
//   in_valid/in_ready   : EX handshake, in_ready registered
//   alu_*, pc, rd, ...  : instruction fields captured on accept
//   out_valid/out_ready : MEM handshake, out_* are the head entry
//   redirect/redirect_pc: taken-branch pulse and target
//   exc/epc/exc_ack     : overflow trap and handler acknowledge
//   flush               : kills buffered entries and the same-cycle accept
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DW      = CPU_DW,
  parameter int unsigned RW      = CPU_RW,
  parameter logic        TRAP_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    alu_ctrl,
  input  logic [DW-1:0] alu_c,
  input  logic          alu_zf,
  input  logic          alu_of,
  input  logic [DW-1:0] pc,
  input  logic [RW-1:0] rd,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          is_beq,
  input  logic [DW-1:0] store_data,
  input  logic [DW-1:0] br_target,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_c,
  output logic [DW-1:0] out_store_data,
  output logic [DW-1:0] out_pc,
  output logic [RW-1:0] out_rd,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          redirect,
  output logic [DW-1:0] redirect_pc,
  output logic          exc,
  output logic [DW-1:0] epc,
  input  logic          exc_ack
);

  exstate_t      r_state;
  logic          r_in_ready;
  logic          r_redirect;
  logic [DW-1:0] r_redirect_pc;
  logic          r_exc;
  logic [DW-1:0] r_epc;

  logic        w_accept;
  logic        w_trap;
  logic        w_take;
  logic        w_skid_v_nxt;
  ex_payload_t w_in_pl;
  ex_payload_t w_out_pl;

  // A flushed cycle discards the accept entirely: no enqueue, trap or redirect.
  assign w_accept = in_valid && r_in_ready && !flush;
  assign w_trap   = TRAP_EN && alu_of && is_signed_arith(alu_ctrl);
  assign w_take   = is_beq && (alu_ctrl == ALU_SUB) && alu_zf && !w_trap;

  always_comb begin
    w_in_pl            = '0;
    w_in_pl.c          = alu_c;
    w_in_pl.store_data = store_data;
    w_in_pl.pc         = pc;
    w_in_pl.rd         = rd;
    w_in_pl.reg_write  = reg_write && !w_trap;
    w_in_pl.mem_read   = mem_read  && !w_trap;
    w_in_pl.mem_write  = mem_write && !w_trap;
  end

  skid_buffer #(
    .W($bits(ex_payload_t))
  ) u_skid (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_flush         (flush),
    .i_push          (w_accept),
    .i_push_data     (w_in_pl),
    .i_pop_ready     (out_ready),
    .o_out_valid     (out_valid),
    .o_out_data      (w_out_pl),
    .o_skid_valid_nxt(w_skid_v_nxt)
  );

  // in_ready is computed from next-state SKID occupancy and next FSM state so
  // the registered value is exact in the cycle it is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_in_ready    <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_exc         <= 1'b0;
      r_epc         <= '0;
    end else begin
      r_redirect <= w_accept && w_take;
      if (w_accept && w_take) begin
        r_redirect_pc <= br_target;
      end
      case (r_state)
        RUN: begin
          if (w_accept && w_trap) begin
            r_state    <= TRAP_HOLD;
            r_exc      <= 1'b1;
            r_epc      <= pc;
            r_in_ready <= 1'b0;
          end else begin
            r_in_ready <= !w_skid_v_nxt;
          end
        end
        TRAP_HOLD: begin
          if (exc_ack) begin
            r_state    <= RUN;
            r_exc      <= 1'b0;
            r_in_ready <= !w_skid_v_nxt;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state    <= RUN;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign redirect       = r_redirect;
  assign redirect_pc    = r_redirect_pc;
  assign exc            = r_exc;
  assign epc            = r_epc;
  assign out_c          = w_out_pl.c;
  assign out_store_data = w_out_pl.store_data;
  assign out_pc         = w_out_pl.pc;
  assign out_rd         = w_out_pl.rd;
  assign out_reg_write  = w_out_pl.reg_write;
  assign out_mem_read   = w_out_pl.mem_read;
  assign out_mem_write  = w_out_pl.mem_write;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the 32-bit ALU.
- Captures the combinational ALU result (value, zero flag, overflow flag) with the instruction's control bits, and resolves BEQ branches from the zero flag.
- Raises a precise overflow trap for signed add/sub.
- Buffers through a 2-entry skid buffer so a memory-stage stall never combinationally reaches decode.

Parameters:
- DW, 32, datapath width (ALU result, store data, PC)
- RW, 5, register-index width
- TRAP_EN, 1, 1 = overflow on ALUCtrl 3'b100/3'b110 traps; 0 = overflow ignored

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX has a valid instruction
- in_ready  out  1  stage can accept; registered
- alu_ctrl  in  3  ALUCtrl driven to the ALU for this instruction
- alu_c  in  DW  ALU result C
- alu_zf  in  1  ALU zero flag
- alu_of  in  1  ALU overflow flag
- pc  in  DW  instruction PC
- rd  in  RW  destination register
- reg_write, mem_read, mem_write, is_beq  in  1 each  decoded control
- store_data  in  DW  rt value for stores
- br_target  in  DW  precomputed branch target
- flush  in  1  synchronous kill of all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM accepts head
- out_c, out_store_data, out_pc  out  DW  head fields
- out_rd  out  RW; out_reg_write, out_mem_read, out_mem_write  out  1 each
- redirect  out  1  one-cycle pulse: taken branch
- redirect_pc  out  DW  target, valid with redirect
- exc  out  1  overflow trap pending (level)
- epc  out  DW  PC of trapping instruction
- exc_ack  in  1  trap handler acknowledges

Behaviour:
- Reset (async, rst_n=0): both buffer entries invalid; out_valid=0; in_ready=0 while rst_n=0, 1 from the first clk edge after deassertion; redirect=0; exc=0; epc=0; all out_* data=0; FSM=RUN.
- Accept on the edge where in_valid&&in_ready.
- Skid buffer: entries MAIN (head) and SKID.
  - in_ready = !SKID.valid && state==RUN, registered.
  - An accept while MAIN is full and not popping writes SKID.
  - A pop (out_valid&&out_ready) promotes SKID to MAIN in the same edge.
  - Simultaneous push+pop with MAIN only: new entry goes to MAIN.
- Latency: 1 cycle input to out_valid with empty buffer. Throughput: 1 per cycle while out_ready=1.
- Trap condition at accept: TRAP_EN && alu_of && (alu_ctrl==3'b100 || alu_ctrl==3'b110).
  - Entry is still enqueued, with reg_write, mem_read and mem_write forced to 0.
  - epc<=pc; exc<=1; FSM RUN->TRAP_HOLD.
- TRAP_HOLD:
  - in_ready=0; draining to MEM continues.
  - exc_ack -> exc<=0, back to RUN; in_ready returns 1 the next cycle.
  - exc_ack in RUN is ignored.
- Branch at accept: is_beq && alu_ctrl==3'b110.
  - If alu_zf=1: redirect=1 for exactly one cycle (the cycle after accept) and redirect_pc<=br_target.
  - BEQ entry is enqueued with reg_write/mem_* as given (decode drives 0).
  - Not taken: no pulse.
- Branch and overflow on the same instruction: trap wins, no redirect.
- flush=1:
  - Both entries invalidated, redirect cleared, out_valid=0 next cycle.
  - An accept in that same cycle is discarded.
  - exc/epc/FSM unaffected; exc is cleared only by exc_ack or reset.
- Boundaries:
  - out_ready=0 for 2 consecutive accepts: SKID full, in_ready drops; no entry is lost or duplicated.
  - Output fields hold stable while out_valid&&!out_ready.
- All arithmetic lives in the ALU; this stage does no width conversion. Fields pass through bit-exact.

Decomposition:
- Shared package cpu_pkg:
  - ALUCtrl encodings: ALU_AND=3'b000, ALU_OR=3'b001, ALU_SLT=3'b011, ALU_ADD=3'b100, ALU_ADDU=3'b101, ALU_SUB=3'b110
  - exstage state enum RUN/TRAP_HOLD
  - payload struct {c, store_data, pc, rd, reg_write, mem_read, mem_write}
- One natural sub-module: skid_buffer, a generic 2-entry valid/ready buffer parameterised by payload width. This top does trap/branch classification and the FSM.

Test Plan:
- Reset then stream 3 ADDU ops (A=1,B=2 -> C=3, etc.) with out_ready=1 -> out_valid one cycle after each accept, out_c=3,… in order, in_ready stays 1.
- Hold out_ready=0 while pushing 3 -> first two accepted, in_ready=0 on the third; release -> all three emerge in order, none lost.
- ADD with alu_c=32'h80000000, alu_of=1, pc=32'h40, reg_write=1 -> exc=1, epc=32'h40, out_reg_write=0, in_ready=0 until exc_ack, then 1 the following cycle.
- BEQ, alu_ctrl=3'b110, alu_zf=1, br_target=32'h100 -> redirect high exactly 1 cycle, redirect_pc=32'h100; zf=0 -> no pulse.
- flush asserted with both entries full and in_valid=1 -> out_valid=0 next cycle, nothing from before or during the flush appears on output.
- rst_n pulsed low mid-stream and asynchronously (between edges) -> outputs 0 immediately, exc cleared, FSM=RUN.
